shared_ram_arbiter: RTL and testbench



---
 rtl/shared_ram_arbiter_pkg.sv | 16 +
 rtl/rr_picker.sv | 28 ++
 rtl/shared_ram_arbiter.sv | 167 ++++++++++++++++
 tb/tb_shared_ram_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_ram_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: FSM state encoding and mode constants.
package shared_ram_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        TURN       = 3'd1,
        OWN        = 3'd2,
        ACC_SETUP  = 3'd3,
        ACC_STROBE = 3'd4,
        ACC_DONE   = 3'd5
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating-priority encoder: first set bit of req at or above ptr, with wrap.
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    int cand;

    // Scan from farthest to nearest so the candidate closest above ptr is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % N;
            if (req[IW'(cand)]) begin
                found = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/shared_ram_arbiter.sv
// N-master arbiter for one asynchronous SRAM port: request/grant handshake, fixed or
// round-robin selection, bus turnaround between owners and a three-cycle access sequence.
module shared_ram_arbiter
    import shared_ram_arbiter_pkg::*;
#(
    parameter int N_MASTERS  = 2,
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16,
    parameter int TURNAROUND = 1,
    localparam int SEL_W     = $clog2(N_MASTERS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mode,
    input  logic [SEL_W-1:0]              sel,
    input  logic [N_MASTERS-1:0]          m_req,
    input  logic [N_MASTERS-1:0]          m_cmd_valid,
    input  logic [N_MASTERS-1:0]          m_we,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    output logic [N_MASTERS-1:0]          m_grant,
    output logic [N_MASTERS-1:0]          m_ack,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [ADDR_W-1:0]             ram_addr,
    inout  wire  [DATA_W-1:0]             ram_data,
    output logic                          ram_en_n,
    output logic                          ram_oe_n,
    output logic                          ram_we_n
);

    localparam logic [1:0] TURN_LAST = 2'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

    state_t               state_reg, state_next;
    logic [SEL_W-1:0]     owner_reg, owner_next;
    logic [SEL_W-1:0]     ptr_reg, ptr_next;
    logic [1:0]           turn_cnt_reg, turn_cnt_next;
    logic [ADDR_W-1:0]    addr_reg;
    logic [DATA_W-1:0]    wdata_reg;
    logic                 we_reg;
    logic [DATA_W-1:0]    rdata_reg;

    logic [ADDR_W-1:0]    addr_arr  [N_MASTERS];
    logic [DATA_W-1:0]    wdata_arr [N_MASTERS];

    logic                 rr_found;
    logic [SEL_W-1:0]     rr_idx;
    logic                 sel_ok;
    logic                 win_found;
    logic [SEL_W-1:0]     win_idx;
    logic [N_MASTERS-1:0] owner_oh;
    logic                 others_req;
    logic                 release_now;
    logic                 capture;
    logic                 sample_rd;
    logic                 in_acc;
    logic                 drive_bus;

    generate
        for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
            assign addr_arr[gi]  = m_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = m_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_picker #(
        .N  (N_MASTERS),
        .IW (SEL_W)
    ) u_rr_picker (
        .req   (m_req),
        .ptr   (ptr_reg),
        .found (rr_found),
        .idx   (rr_idx)
    );

    assign sel_ok      = (int'(sel) < N_MASTERS) && m_req[sel];
    assign win_found   = (mode == MODE_RR) ? rr_found : sel_ok;
    assign win_idx     = (mode == MODE_RR) ? rr_idx : sel;
    assign owner_oh    = {{(N_MASTERS-1){1'b0}}, 1'b1} << owner_reg;
    assign others_req  = |(m_req & ~owner_oh);
    assign release_now = !m_req[owner_reg]
                       || ((mode == MODE_FIXED) && (sel != owner_reg))
                       || ((mode == MODE_RR) && others_req);

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        ptr_next      = ptr_reg;
        turn_cnt_next = turn_cnt_reg;
        capture       = 1'b0;
        sample_rd     = 1'b0;
        case (state_reg)
            IDLE: begin
                turn_cnt_next = '0;
                if (win_found) begin
                    owner_next = win_idx;
                    state_next = (TURNAROUND == 0) ? OWN : TURN;
                end
            end
            TURN: begin
                if (turn_cnt_reg == TURN_LAST) begin
                    state_next = OWN;
                end else begin
                    turn_cnt_next = turn_cnt_reg + 2'd1;
                end
            end
            OWN: begin
                // A pending command always wins over release, so an owner is never cut off mid-request.
                if (m_cmd_valid[owner_reg]) begin
                    capture    = 1'b1;
                    state_next = ACC_SETUP;
                end else if (release_now) begin
                    state_next = IDLE;
                    if (mode == MODE_RR) begin
                        ptr_next = (int'(owner_reg) == N_MASTERS - 1) ? '0 : owner_reg + 1'b1;
                    end
                end
            end
            ACC_SETUP:  state_next = ACC_STROBE;
            ACC_STROBE: begin
                sample_rd  = !we_reg;
                state_next = ACC_DONE;
            end
            ACC_DONE:   state_next = OWN;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            owner_reg    <= '0;
            ptr_reg      <= '0;
            turn_cnt_reg <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            we_reg       <= 1'b0;
            rdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            ptr_reg      <= ptr_next;
            turn_cnt_reg <= turn_cnt_next;
            if (capture) begin
                addr_reg  <= addr_arr[owner_reg];
                wdata_reg <= wdata_arr[owner_reg];
                we_reg    <= m_we[owner_reg];
            end
            if (sample_rd) begin
                rdata_reg <= ram_data;
            end
        end
    end

    // Outputs decode from registered state only, so a reset edge clears them immediately.
    assign in_acc    = (state_reg == ACC_SETUP) || (state_reg == ACC_STROBE);
    assign drive_bus = in_acc && we_reg;
    assign m_grant   = ((state_reg == OWN) || (state_reg == ACC_SETUP) ||
                        (state_reg == ACC_STROBE) || (state_reg == ACC_DONE)) ? owner_oh : '0;
    assign m_ack     = (state_reg == ACC_DONE) ? owner_oh : '0;
    assign m_rdata   = rdata_reg;
    assign ram_addr  = addr_reg;
    assign ram_en_n  = !in_acc;
    assign ram_we_n  = !((state_reg == ACC_STROBE) && we_reg);
    assign ram_oe_n  = !((state_reg == ACC_STROBE) && !we_reg);
    assign ram_data  = drive_bus ? wdata_reg : 'z;

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Bench for shared_ram_arbiter (N=4, TURNAROUND=1): directed steps then random traffic,
// every cycle checked against a tenure/countdown reference model and a shadow memory.
module tb_shared_ram_arbiter;

    localparam int N  = 4;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int TA = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mode = 1'b0;
    logic [1:0]        sel = 2'd0;
    logic [N-1:0]      m_req = '0;
    logic [N-1:0]      m_cmd_valid = '0;
    logic [N-1:0]      m_we = '0;
    logic [N*AW-1:0]   m_addr = '0;
    logic [N*DW-1:0]   m_wdata = '0;
    wire  [N-1:0]      m_grant;
    wire  [N-1:0]      m_ack;
    wire  [DW-1:0]     m_rdata;
    wire  [AW-1:0]     ram_addr;
    wire  [DW-1:0]     ram_data;
    wire               ram_en_n;
    wire               ram_oe_n;
    wire               ram_we_n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shared_ram_arbiter #(
        .N_MASTERS  (N),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .TURNAROUND (TA)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .sel         (sel),
        .m_req       (m_req),
        .m_cmd_valid (m_cmd_valid),
        .m_we        (m_we),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_grant     (m_grant),
        .m_ack       (m_ack),
        .m_rdata     (m_rdata),
        .ram_addr    (ram_addr),
        .ram_data    (ram_data),
        .ram_en_n    (ram_en_n),
        .ram_oe_n    (ram_oe_n),
        .ram_we_n    (ram_we_n)
    );

    // Board SRAM: drives the bus on read strobe, captures writes mid-strobe; pull-ups make an undriven bus read all ones.
    logic [DW-1:0] sram [256];
    bit            sram_inited = 1'b0;

    assign ram_data = (!ram_en_n && !ram_oe_n) ? sram[ram_addr[7:0]] : 'z;

    generate
        for (genvar gi = 0; gi < DW; gi++) begin : g_pu
            pullup pu (ram_data[gi]);
        end
    endgenerate

    always @(negedge clk) begin
        if (!sram_inited) begin
            for (int i = 0; i < 256; i++) sram[i] = '0;
            sram_inited = 1'b1;
        end
        if (!ram_en_n && !ram_we_n) sram[ram_addr[7:0]] = ram_data;
    end

    // Reference model: own = current tenure holder (-1 none), gap = turnaround cycles left,
    // acc = access cycles left (3 setup, 2 strobe, 1 ack).
    int            own = -1;
    int            gap = 0;
    int            acc = 0;
    int            ptr = 0;
    int            w_m;
    logic          c_we = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_rdata = '0;
    logic [DW-1:0] model_mem [256];
    bit            model_inited = 1'b0;

    function automatic int pick();
        int i;
        if (mode == 1'b0) return m_req[sel] ? int'(sel) : -1;
        for (int k = 0; k < N; k++) begin
            i = (ptr + k) % N;
            if (m_req[i[1:0]]) return i;
        end
        return -1;
    endfunction

    function automatic bit leave_now();
        logic [N-1:0] others;
        others = m_req & ~(4'b0001 << own[1:0]);
        return !m_req[own[1:0]] || (!mode && int'(sel) != own) || (mode && others != '0);
    endfunction

    always @(posedge clk) begin
        if (!model_inited) begin
            for (int i = 0; i < 256; i++) model_mem[i] = '0;
            model_inited = 1'b1;
        end
        if (acc == 2 && c_we) model_mem[c_addr[7:0]] = c_wdata;
        if (rst) begin
            own = -1; gap = 0; acc = 0; ptr = 0;
            exp_addr = '0; exp_rdata = '0;
        end else if (own < 0) begin
            w_m = pick();
            if (w_m >= 0) begin own = w_m; gap = TA; end
        end else if (gap > 0) begin
            gap--;
        end else if (acc > 0) begin
            if (acc == 2 && !c_we) exp_rdata = model_mem[c_addr[7:0]];
            acc--;
        end else if (m_cmd_valid[own[1:0]]) begin
            c_we     = m_we[own[1:0]];
            c_addr   = m_addr[own*AW +: AW];
            c_wdata  = m_wdata[own*DW +: DW];
            exp_addr = c_addr;
            acc      = 3;
        end else if (leave_now()) begin
            if (mode) ptr = (own + 1) % N;
            own = -1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle();
        logic [N-1:0]  e_grant;
        logic [N-1:0]  e_ack;
        logic [DW-1:0] e_bus;
        bit            owned;
        owned   = (own >= 0) && (gap == 0);
        e_grant = owned ? (4'b0001 << own[1:0]) : '0;
        e_ack   = (owned && acc == 1) ? (4'b0001 << own[1:0]) : '0;
        if ((acc == 3 || acc == 2) && c_we) e_bus = c_wdata;
        else if (acc == 2)                  e_bus = model_mem[c_addr[7:0]];
        else                                e_bus = '1;
        chk("grant",   m_grant, e_grant);
        chk("ack",     m_ack, e_ack);
        chk("rdata",   m_rdata, exp_rdata);
        chk("addr",    ram_addr, exp_addr);
        chk("en_n",    ram_en_n, !(acc == 3 || acc == 2));
        chk("we_n",    ram_we_n, !(acc == 2 && c_we));
        chk("oe_n",    ram_oe_n, !(acc == 2 && !c_we));
        chk("bus",     ram_data, e_bus);
        if (e_ack != '0)
            $display("txn m%0d %s addr=%h data=%h", own, c_we ? "WR" : "RD", c_addr,
                     c_we ? c_wdata : exp_rdata);
    endtask

    task automatic cyc();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic set_cmd(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_cmd_valid = '0;
        m_cmd_valid[i[1:0]] = 1'b1;
        m_we[i[1:0]] = we;
        m_addr[i*AW +: AW] = a;
        m_wdata[i*DW +: DW] = d;
    endtask

    task automatic wait_grant(input int i, input int limit, output int lat);
        lat = 0;
        while (m_grant[i[1:0]] !== 1'b1 && lat < limit) begin cyc(); lat++; end
        chk("grant_seen", 32'(m_grant[i[1:0]]), 32'd1);
    endtask

    task automatic wait_any_grant(input int limit, output int lat);
        lat = 0;
        while (m_grant === '0 && lat < limit) begin cyc(); lat++; end
        chk("any_grant_seen", 32'(m_grant != '0), 32'd1);
    endtask

    task automatic wait_release(input int limit);
        int n = 0;
        while (m_grant !== '0 && n < limit) begin cyc(); n++; end
        chk("release_seen", m_grant, 32'd0);
    endtask

    task automatic wait_ack(input int i, input int limit, output int lat, output int we_lo);
        lat = 0; we_lo = 0;
        while (m_ack[i[1:0]] !== 1'b1 && lat < limit) begin
            cyc(); lat++;
            if (ram_we_n === 1'b0) we_lo++;
        end
        chk("ack_seen", 32'(m_ack[i[1:0]]), 32'd1);
    endtask

    initial begin
        int lat;
        int we_lo;
        int o;

        repeat (3) cyc();
        chk("rst_grant", m_grant, 0);
        chk("rst_strobes", {ram_en_n, ram_oe_n, ram_we_n}, 3'b111);
        chk("rst_bus", ram_data, 16'hFFFF);
        rst = 1'b0;

        // Fixed mode, master 1: write then read back.
        mode = 1'b0; sel = 2'd1; m_req = 4'b0010;
        wait_grant(1, 10, lat);
        chk("grant_latency", lat, TA + 1);
        set_cmd(1, 1'b1, 18'h00012, 16'hBEEF);
        cyc(); m_cmd_valid = '0;
        wait_ack(1, 10, lat, we_lo);
        chk("wr_ack_latency", lat + 1, 3);
        chk("wr_we_pulse", we_lo, 1);
        cyc();
        chk("bus_z_after_wr", ram_data, 16'hFFFF);
        set_cmd(1, 1'b0, 18'h00012, 16'h0000);
        cyc(); m_cmd_valid = '0;
        wait_ack(1, 10, lat, we_lo);
        chk("rd_ack_latency", lat + 1, 3);
        chk("rd_data", m_rdata, 16'hBEEF);
        chk("rd_we_quiet", we_lo, 0);
        m_req = '0;
        wait_release(10);

        // Round-robin, all requesting: one access per tenure.
        mode = 1'b1; m_req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            o = t % N;
            wait_release(10);
            wait_any_grant(20, lat);
            chk("rr_order", m_grant, 4'b0001 << o);
            chk("rr_gap", 32'(lat >= 1), 32'd1);
            set_cmd(o, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)), DW'($urandom));
            cyc(); m_cmd_valid = '0;
            wait_ack(o, 10, lat, we_lo);
        end
        m_req = '0;
        wait_release(10);

        // Fixed mode: sel moves during master 0's strobe; access still completes.
        mode = 1'b0; sel = 2'd0; m_req = 4'b0011;
        wait_grant(0, 10, lat);
        set_cmd(0, 1'b1, 18'h00040, 16'h1234);
        cyc(); m_cmd_valid = '0;
        cyc();
        chk("strobe_we_low", ram_we_n, 1'b0);
        sel = 2'd1;
        wait_ack(0, 10, lat, we_lo);
        wait_release(10);
        wait_grant(1, 10, lat);
        chk("switch_grant_latency", lat, TA + 1);

        // Master 2 is not granted: its command must be ignored.
        m_we[2] = 1'b1;
        m_cmd_valid = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            cyc();
            m_cmd_valid = '0;
            chk("ungranted_ack", m_ack[2], 1'b0);
            chk("ungranted_en", ram_en_n, 1'b1);
        end

        // Reset during a write strobe.
        set_cmd(1, 1'b1, 18'h00055, 16'hCAFE);
        cyc(); m_cmd_valid = '0;
        cyc();
        chk("pre_rst_we", ram_we_n, 1'b0);
        rst = 1'b1;
        cyc();
        chk("mid_rst_strobes", {ram_en_n, ram_oe_n, ram_we_n}, 3'b111);
        chk("mid_rst_grant", m_grant, 0);
        chk("mid_rst_ack", m_ack, 0);
        chk("mid_rst_bus", ram_data, 16'hFFFF);
        rst = 1'b0;

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) == 0) mode = ~mode;
            if ($urandom_range(0, 49) == 0) sel = 2'($urandom_range(0, 3));
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) m_req[b] = ~m_req[b];
                m_cmd_valid[b] = ($urandom_range(0, 2) == 0);
                m_we[b] = 1'($urandom_range(0, 1));
                m_addr[b*AW +: AW] = {10'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
                m_wdata[b*DW +: DW] = DW'($urandom);
            end
            rst = ($urandom_range(0, 399) == 0);
            cyc();
        end
        rst = 1'b0;
        m_cmd_valid = '0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
